// File: rtl/shield_write_slave_if.sv
// Bundles the write-data slave's three handshakes: the AXI W channel, the line request and the assembled-line output.
interface shield_write_slave_if #(
   parameter int CL_ID_WIDTH     = 6,
   parameter int CL_DATA_WIDTH   = 64,
   parameter int LINE_WIDTH      = 512,
   parameter int OFFSET_WIDTH    = 6,
   parameter int BURSTS_PER_LINE = 8
);
   logic [CL_ID_WIDTH-1:0]       s_axi_wid;
   logic [CL_DATA_WIDTH-1:0]     s_axi_wdata;
   logic [CL_DATA_WIDTH/8-1:0]   s_axi_wstrb;
   logic                         s_axi_wlast;
   logic                         s_axi_wvalid;
   logic                         s_axi_wready;

   logic [7:0]                   burst_count;
   logic [OFFSET_WIDTH-1:0]      burst_start_offset;
   logic                         req_val;
   logic                         req_rdy;

   logic [LINE_WIDTH-1:0]        cache_line;
   logic [BURSTS_PER_LINE-1:0]   cache_line_burst_en;
   logic                         cache_line_val;
   logic                         cache_line_rdy;

   modport slave (
      input  s_axi_wid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
      output s_axi_wready,
      input  burst_count, burst_start_offset, req_val,
      output req_rdy,
      output cache_line, cache_line_burst_en, cache_line_val,
      input  cache_line_rdy
   );

   modport master (
      output s_axi_wid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
      input  s_axi_wready,
      output burst_count, burst_start_offset, req_val,
      input  req_rdy,
      input  cache_line, cache_line_burst_en, cache_line_val,
      output cache_line_rdy
   );
endinterface

// File: rtl/shield_write_slave.sv
// AXI write-data slave: gathers a counted burst of W beats into their slots of one cache line
// and hands the line plus a per-slot enable mask to the line writer.
module shield_write_slave #(
   parameter int CL_DATA_WIDTH       = 64,
   parameter int LINE_WIDTH          = 512,
   parameter int OFFSET_WIDTH        = 6,
   parameter int BURSTS_PER_LINE     = 8,
   parameter int BURSTS_PER_LINE_LOG = 3
) (
   input logic                 clk,
   input logic                 rst,
   shield_write_slave_if.slave bus
);

   typedef enum logic [1:0] {IDLE, DATA, OUT} state_t;

   state_t                         state;
   logic [LINE_WIDTH-1:0]          line_q;
   logic [BURSTS_PER_LINE-1:0]     mask_q;
   logic [7:0]                     remaining;
   logic [BURSTS_PER_LINE_LOG-1:0] idx;
   logic                           wready_q;
   logic                           val_q;
   logic                           unused_inputs;

   assign unused_inputs = ^{bus.s_axi_wid, bus.s_axi_wstrb, bus.s_axi_wlast,
                            bus.burst_start_offset[OFFSET_WIDTH-BURSTS_PER_LINE_LOG-1:0]};

   assign bus.req_rdy             = (state == IDLE);
   assign bus.s_axi_wready        = wready_q;
   assign bus.cache_line_val      = val_q;
   assign bus.cache_line          = line_q;
   assign bus.cache_line_burst_en = mask_q;

   // wready drops for one cycle after every accepted beat, capping intake at one beat per two cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         line_q    <= '0;
         mask_q    <= '0;
         remaining <= '0;
         idx       <= '0;
         wready_q  <= 1'b0;
         val_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_val) begin
                  remaining <= bus.burst_count;
                  idx       <= bus.burst_start_offset[OFFSET_WIDTH-1 -: BURSTS_PER_LINE_LOG];
                  line_q    <= '0;
                  mask_q    <= '0;
                  if (bus.burst_count == 8'd0) begin
                     state <= OUT;
                     val_q <= 1'b1;
                  end else begin
                     state    <= DATA;
                     wready_q <= 1'b1;
                  end
               end
            end
            DATA: begin
               if (bus.s_axi_wvalid && wready_q) begin
                  line_q[idx*CL_DATA_WIDTH +: CL_DATA_WIDTH] <= bus.s_axi_wdata;
                  mask_q[idx] <= 1'b1;
                  idx         <= idx + 1'b1;
                  remaining   <= remaining - 8'd1;
                  wready_q    <= 1'b0;
                  if (remaining == 8'd1) begin
                     state <= OUT;
                     val_q <= 1'b1;
                  end
               end else begin
                  wready_q <= 1'b1;
               end
            end
            OUT: begin
               if (bus.cache_line_rdy) begin
                  state  <= IDLE;
                  line_q <= '0;
                  mask_q <= '0;
                  val_q  <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               wready_q <= 1'b0;
               val_q    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shield_write_slave.sv
// Directed, table-driven bench for shield_write_slave: each vector is a request whose assembled line
// and enable mask are compared against hand-computed slot contents.
module tb_shield_write_slave;

   typedef struct {
      int               count;
      logic [5:0]       offset;
      bit               hold_extra;
      logic [7:0]       exp_en;
      logic [7:0][7:0]  exp_slot;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[8];

   shield_write_slave_if bus ();

   shield_write_slave dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [511:0] expandSlots(input logic [7:0][7:0] s);
      logic [511:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r[i*64 +: 64] = 64'(s[i]);
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Issues one request and streams beats k+1 with wvalid held continuously across the dead cycles
   task automatic applyStimulus(input int count, input logic [5:0] offset, input bit hold_extra);
      int guard;
      @(negedge clk);
      checkOutput("req_rdy_idle", 512'(bus.req_rdy), 512'(1));
      bus.req_val            = 1'b1;
      bus.burst_count        = count[7:0];
      bus.burst_start_offset = offset;
      @(negedge clk);
      bus.req_val = 1'b0;
      checkOutput("req_rdy_busy", 512'(bus.req_rdy), 512'(0));
      if (count == 0) checkOutput("val_empty", 512'(bus.cache_line_val), 512'(1));
      else            checkOutput("wready_first", 512'(bus.s_axi_wready), 512'(1));
      for (int k = 0; k < count; k++) begin
         bus.s_axi_wvalid = 1'b1;
         bus.s_axi_wdata  = 64'(k + 1);
         guard = 0;
         while (!bus.s_axi_wready && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 20) begin
            checkOutput("wready_timeout", 512'(0), 512'(1));
            break;
         end
         @(negedge clk);
         checkOutput("wready_gap", 512'(bus.s_axi_wready), 512'(0));
         if (k == count - 1) checkOutput("val_latency", 512'(bus.cache_line_val), 512'(1));
         if (hold_extra) @(negedge clk);
      end
      bus.s_axi_wvalid = 1'b0;
   endtask

   task automatic verifyLine(input vec_t v);
      checkOutput("line", bus.cache_line, expandSlots(v.exp_slot));
      checkOutput("burst_en", 512'(bus.cache_line_burst_en), 512'(v.exp_en));
      checkOutput("val", 512'(bus.cache_line_val), 512'(1));
      @(negedge clk);
      checkOutput("val_hold", 512'(bus.cache_line_val), 512'(1));
      checkOutput("line_hold", bus.cache_line, expandSlots(v.exp_slot));
      bus.cache_line_rdy = 1'b1;
      @(negedge clk);
      bus.cache_line_rdy = 1'b0;
      checkOutput("val_drop", 512'(bus.cache_line_val), 512'(0));
      checkOutput("en_clear", 512'(bus.cache_line_burst_en), 512'(0));
      checkOutput("line_clear", bus.cache_line, 512'(0));
      checkOutput("req_rdy_back", 512'(bus.req_rdy), 512'(1));
   endtask

   initial begin
      vecs[0] = '{1, 6'h00, 1'b0, 8'h01, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1}};
      vecs[1] = '{8, 6'h00, 1'b1, 8'hFF, {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}};
      vecs[2] = '{3, 6'h08, 1'b0, 8'h0E, {8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd2, 8'd1, 8'd0}};
      vecs[3] = '{1, 6'h38, 1'b1, 8'h80, {8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
      vecs[4] = '{2, 6'h30, 1'b0, 8'hC0, {8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
      vecs[5] = '{2, 6'h10, 1'b0, 8'h0C, {8'd0, 8'd0, 8'd0, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0}};
      vecs[6] = '{0, 6'h00, 1'b0, 8'h00, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
      vecs[7] = '{1, 6'h0F, 1'b0, 8'h02, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0}};

      bus.s_axi_wid          = '1;
      bus.s_axi_wdata        = '0;
      bus.s_axi_wstrb        = '0;
      bus.s_axi_wlast        = 1'b1;
      bus.s_axi_wvalid       = 1'b0;
      bus.burst_count        = '0;
      bus.burst_start_offset = '0;
      bus.req_val            = 1'b0;
      bus.cache_line_rdy     = 1'b0;

      repeat (2) @(negedge clk);
      checkOutput("rst_wready", 512'(bus.s_axi_wready), 512'(0));
      checkOutput("rst_val", 512'(bus.cache_line_val), 512'(0));
      checkOutput("rst_line", bus.cache_line, 512'(0));
      checkOutput("rst_en", 512'(bus.cache_line_burst_en), 512'(0));
      checkOutput("rst_req_rdy", 512'(bus.req_rdy), 512'(1));
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].count, vecs[i].offset, vecs[i].hold_extra);
         verifyLine(vecs[i]);
      end

      // Reset lands mid-burst after one of three beats; the following request must start clean
      @(negedge clk);
      bus.req_val            = 1'b1;
      bus.burst_count        = 8'd3;
      bus.burst_start_offset = 6'h00;
      @(negedge clk);
      bus.req_val      = 1'b0;
      bus.s_axi_wvalid = 1'b1;
      bus.s_axi_wdata  = 64'hDEAD;
      @(negedge clk);
      bus.s_axi_wvalid = 1'b0;
      @(negedge clk);
      checkOutput("mid_wready", 512'(bus.s_axi_wready), 512'(1));
      checkOutput("mid_en", 512'(bus.cache_line_burst_en), 512'(8'h01));
      rst = 1'b1;
      #1;
      checkOutput("arst_wready", 512'(bus.s_axi_wready), 512'(0));
      checkOutput("arst_val", 512'(bus.cache_line_val), 512'(0));
      checkOutput("arst_req_rdy", 512'(bus.req_rdy), 512'(1));
      checkOutput("arst_en", 512'(bus.cache_line_burst_en), 512'(0));
      checkOutput("arst_line", bus.cache_line, 512'(0));
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(vecs[5].count, vecs[5].offset, vecs[5].hold_extra);
      verifyLine(vecs[5]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
